// File: rtl/booth_radix4_digit_mac_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : booth_radix4_digit_mac_if                                      |
// | Description: Request/response bundle for the radix-4 Booth digit MAC.       |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
interface booth_radix4_digit_mac_if #(
  parameter int WIDTH = 8
);
  localparam int c_nd = WIDTH / 2 + 1;

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [WIDTH-1:0]     multiplicand_i;
  logic                 unsigned_i;
  logic [c_nd-1:0]      is_zero_i;
  logic [c_nd-1:0]      is_neg_double_i;
  logic [c_nd-1:0]      is_neg_one_i;
  logic [c_nd-1:0]      is_pos_double_i;
  logic [c_nd-1:0]      is_pos_one_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [2*WIDTH-1:0]   product_o;
  logic                 busy_o;
  logic                 err_o;

  modport slave (
    input  in_valid_i, multiplicand_i, unsigned_i, is_zero_i, is_neg_double_i,
           is_neg_one_i, is_pos_double_i, is_pos_one_i, out_ready_i,
    output in_ready_o, out_valid_o, product_o, busy_o, err_o
  );

  modport master (
    output in_valid_i, multiplicand_i, unsigned_i, is_zero_i, is_neg_double_i,
           is_neg_one_i, is_pos_double_i, is_pos_one_i, out_ready_i,
    input  in_ready_o, out_valid_o, product_o, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/booth_radix4_digit_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : booth_radix4_digit_mac                                         |
// | Description: Iterative multiplier consuming radix-4 Booth digit flags, one  |
// |              shifted partial product per cycle. Optional one-hot digit      |
// |              check enabled by BOOTH_DIGIT_ONEHOT_CHK_EN.                    |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module booth_radix4_digit_mac #(
  parameter int WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  booth_radix4_digit_mac_if.slave bus
);
  localparam int c_nd = WIDTH / 2 + 1;
  localparam int c_pw = 2 * WIDTH;
  localparam int c_kw = $clog2(c_nd);
  localparam logic [c_kw-1:0] c_k_last = c_kw'(c_nd - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]      r_state;
  logic [c_pw-1:0] r_mcand;
  logic [c_nd-1:0] r_neg2, r_neg1, r_pos2, r_pos1;
  logic [c_pw-1:0] r_acc;
  logic [c_kw-1:0] r_k;
  logic [c_pw-1:0] r_product;
  logic            r_err;

  logic            w_accept;
  logic            w_last;
  logic [c_pw-1:0] w_m2;
  logic [c_pw-1:0] w_sum;
  logic [c_pw-1:0] w_acc_next;

  assign w_accept = (r_state == c_idle) && bus.in_valid_i;
  assign w_last   = (r_state == c_run) && (r_k == c_k_last);

  // Flags are summed rather than muxed so malformed digits stay deterministic.
  assign w_m2       = {r_mcand[c_pw-2:0], 1'b0};
  assign w_sum      = (r_pos1[r_k] ? r_mcand : '0)
                    + (r_pos2[r_k] ? w_m2    : '0)
                    - (r_neg1[r_k] ? r_mcand : '0)
                    - (r_neg2[r_k] ? w_m2    : '0);
  assign w_acc_next = r_acc + (w_sum << {r_k, 1'b0});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= c_idle;
      r_mcand   <= '0;
      r_neg2    <= '0;
      r_neg1    <= '0;
      r_pos2    <= '0;
      r_pos1    <= '0;
      r_acc     <= '0;
      r_k       <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.in_valid_i) begin
            r_mcand <= bus.unsigned_i
                     ? {{WIDTH{1'b0}}, bus.multiplicand_i}
                     : {{WIDTH{bus.multiplicand_i[WIDTH-1]}}, bus.multiplicand_i};
            r_neg2  <= bus.is_neg_double_i;
            r_neg1  <= bus.is_neg_one_i;
            r_pos2  <= bus.is_pos_double_i;
            r_pos1  <= bus.is_pos_one_i;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= c_run;
          end
        end
        c_run: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 1'b1;
          if (r_k == c_k_last) begin
            r_product <= w_acc_next;
            r_state   <= c_done;
          end
        end
        c_done: begin
          if (bus.out_ready_i) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef BOOTH_DIGIT_ONEHOT_CHK_EN
  logic [c_nd-1:0] w_digit_bad;
  logic            r_err_pend;

  for (genvar g = 0; g < c_nd; g++) begin : g_chk
    logic [2:0] w_cnt;
    assign w_cnt = {2'b00, bus.is_zero_i[g]} + {2'b00, bus.is_neg_double_i[g]}
                 + {2'b00, bus.is_neg_one_i[g]} + {2'b00, bus.is_pos_double_i[g]}
                 + {2'b00, bus.is_pos_one_i[g]};
    assign w_digit_bad[g] = (w_cnt != 3'd1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err_pend <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err_pend <= |w_digit_bad;
      end
      if (w_last) begin
        r_err <= r_err_pend;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^bus.is_zero_i;
  assign r_err    = 1'b0;
`endif

  assign bus.in_ready_o  = (r_state == c_idle);
  assign bus.out_valid_o = (r_state == c_done);
  assign bus.busy_o      = (r_state != c_idle);
  assign bus.product_o   = r_product;
  assign bus.err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_booth_radix4_digit_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_booth_radix4_digit_mac                                      |
// | Description: Directed scoreboard bench for booth_radix4_digit_mac (W=8).    |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_booth_radix4_digit_mac;
  logic clk_i;
  logic rst_ni;
  int   n_assert;
  int   n_fail;
  logic [15:0] q_prod[$];
  logic        q_err[$];

`ifdef BOOTH_DIGIT_ONEHOT_CHK_EN
  localparam bit c_chk_on = 1'b1;
`else
  localparam bit c_chk_on = 1'b0;
`endif

  booth_radix4_digit_mac_if #(.WIDTH(8)) bus();

  booth_radix4_digit_mac #(.WIDTH(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Radix-4 Booth recoding of the multiplier, digit k from bits (2k+1, 2k, 2k-1).
  task automatic encode(input logic [7:0] b, input logic uns,
                        output logic [4:0] z, output logic [4:0] n2, output logic [4:0] n1,
                        output logic [4:0] p2, output logic [4:0] p1);
    logic [10:0] y;
    logic [2:0]  bits;
    y  = {(uns ? 2'b00 : {2{b[7]}}), b, 1'b0};
    z  = '0; n2 = '0; n1 = '0; p2 = '0; p1 = '0;
    for (int k = 0; k < 5; k++) begin
      bits = {y[2*k+2], y[2*k+1], y[2*k]};
      case (bits)
        3'b001, 3'b010: p1[k] = 1'b1;
        3'b011:         p2[k] = 1'b1;
        3'b100:         n2[k] = 1'b1;
        3'b101, 3'b110: n1[k] = 1'b1;
        default:        z[k]  = 1'b1;
      endcase
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic uns, input logic inject);
    logic [4:0]  z, n2, n1, p2, p1;
    logic [15:0] ext, e;
    int t;
    encode(b, uns, z, n2, n1, p2, p1);
    ext = uns ? {8'h00, a} : {{8{a[7]}}, a};
    e   = uns ? ext * {8'h00, b} : ext * {{8{b[7]}}, b};
    if (inject) begin
      n1[0] = 1'b1;
      e     = e - ext;
    end
    t = 0;
    while (bus.in_ready_o !== 1'b1 && t < 50) begin
      @(posedge clk_i); #1;
      t++;
    end
    chk("in_ready_wait", 16'(bus.in_ready_o), 16'd1);
    bus.multiplicand_i  = a;
    bus.unsigned_i      = uns;
    bus.is_zero_i       = z;
    bus.is_neg_double_i = n2;
    bus.is_neg_one_i    = n1;
    bus.is_pos_double_i = p2;
    bus.is_pos_one_i    = p1;
    bus.in_valid_i      = 1'b1;
    @(posedge clk_i); #1;
    bus.in_valid_i      = 1'b0;
    q_prod.push_back(e);
    q_err.push_back(inject & c_chk_on);
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid_o is seen.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.out_valid_o !== 1'b1 && lat < 30) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("out_valid_wait", 16'(bus.out_valid_o), 16'd1);
  endtask

  task automatic finish_result(input string tag);
    logic [15:0] e;
    logic        er;
    e  = q_prod.pop_front();
    er = q_err.pop_front();
    chk({tag, "_product"}, bus.product_o, e);
    chk({tag, "_err"}, 16'(bus.err_o), 16'(er));
    bus.out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.out_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, 16'(bus.out_valid_o), 16'd0);
    chk({tag, "_ready_back"}, 16'(bus.in_ready_o), 16'd1);
    chk({tag, "_product_held"}, bus.product_o, e);
  endtask

  initial begin
    int lat;
    logic [15:0] held;
    n_assert = 0;
    n_fail   = 0;
    rst_ni              = 1'b0;
    bus.in_valid_i      = 1'b0;
    bus.out_ready_i     = 1'b0;
    bus.multiplicand_i  = '0;
    bus.unsigned_i      = 1'b0;
    bus.is_zero_i       = '0;
    bus.is_neg_double_i = '0;
    bus.is_neg_one_i    = '0;
    bus.is_pos_double_i = '0;
    bus.is_pos_one_i    = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_in_ready", 16'(bus.in_ready_o), 16'd1);
    chk("rst_out_valid", 16'(bus.out_valid_o), 16'd0);
    chk("rst_busy", 16'(bus.busy_o), 16'd0);
    chk("rst_product", bus.product_o, 16'd0);
    chk("rst_err", 16'(bus.err_o), 16'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    send(8'hFD, 8'h05, 1'b0, 1'b0);
    chk("run_busy", 16'(bus.busy_o), 16'd1);
    chk("run_in_ready", 16'(bus.in_ready_o), 16'd0);
    wait_valid(lat);
    chk("latency", 16'(lat), 16'd6);
    finish_result("signed_m3x5");

    send(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_valid(lat);
    finish_result("unsigned_ffxff");

    send(8'h80, 8'h80, 1'b0, 1'b0);
    wait_valid(lat);
    finish_result("signed_80x80");

    send(8'h7F, 8'h80, 1'b0, 1'b0);
    wait_valid(lat);
    finish_result("signed_7fx80");

    // Backpressure: result must hold while stray requests are ignored.
    send(8'h9C, 8'hB7, 1'b1, 1'b0);
    wait_valid(lat);
    held = q_prod[0];
    for (int i = 0; i < 10; i++) begin
      bus.in_valid_i     = (i % 2 == 0);
      bus.multiplicand_i = 8'(i * 17 + 3);
      @(posedge clk_i); #1;
      chk("bp_valid", 16'(bus.out_valid_o), 16'd1);
      chk("bp_product", bus.product_o, held);
      chk("bp_in_ready", 16'(bus.in_ready_o), 16'd0);
      chk("bp_err", 16'(bus.err_o), 16'(q_err[0]));
    end
    bus.in_valid_i = 1'b0;
    finish_result("bp");
    @(posedge clk_i); #1;
    chk("bp_no_phantom", 16'(bus.busy_o), 16'd0);

    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      wait_valid(lat);
      chk("rand_latency", 16'(lat), 16'd6);
      finish_result("rand");
    end

    // Asynchronous reset in the middle of a run discards the partial result.
    send(8'h55, 8'h33, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_in_ready", 16'(bus.in_ready_o), 16'd1);
    chk("mid_rst_out_valid", 16'(bus.out_valid_o), 16'd0);
    chk("mid_rst_busy", 16'(bus.busy_o), 16'd0);
    chk("mid_rst_product", bus.product_o, 16'd0);
    chk("mid_rst_err", 16'(bus.err_o), 16'd0);
    void'(q_prod.pop_back());
    void'(q_err.pop_back());
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    send(8'h03, 8'h03, 1'b0, 1'b0);
    wait_valid(lat);
    finish_result("post_reset_3x3");

    // Digit 0 carries both +1 and -1.
    send(8'h03, 8'h05, 1'b0, 1'b1);
    wait_valid(lat);
    finish_result("dual_flag");

    send(8'h03, 8'h05, 1'b0, 1'b0);
    wait_valid(lat);
    finish_result("err_clears");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
